// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: latch enables/flushes, PC control, memory gating,
// run/halt state and saturating stall/redirect counters.
module pipe_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             mem_taken,
   input  logic             idex_memRead,
   input  logic [4:0]       idex_rt,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             pc_redirect,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

   state_t state;
   logic   dstall;
   logic   luse;
   logic   halted;

   assign dstall = (mem_dREN | mem_dWEN) & ~dhit;
   assign luse   = idex_memRead & (idex_rt != 5'd0) &
                   ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
   // A reset cycle behaves as RUN even if the register still says HALTED.
   assign halted = (state == HALTED) & ~RST;

   always_comb begin
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      imemREN     = 1'b0;
      dmemREN     = 1'b0;
      dmemWEN     = 1'b0;
      if (!halted) begin
         imemREN = 1'b1;
         dmemREN = mem_dREN;
         dmemWEN = mem_dWEN;
         if (wb_halt || dstall) begin
            pc_en = 1'b0;
         end else if (mem_taken) begin
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (luse) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else if (!ihit) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= RUN;
         halt      <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (state != HALTED) begin
         if (wb_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
         end else if (dstall) begin
            state <= DWAIT;
         end else begin
            state <= RUN;
         end
         if (!pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (pc_redirect && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expected outputs queued at drive time, checked mid-cycle.
module tb_pipe_ctrl;

   logic        CLK = 1'b0;
   logic        RST, ihit, dhit, mem_dREN, mem_dWEN, mem_taken, idex_memRead, wb_halt;
   logic [4:0]  idex_rt, ifid_rs, ifid_rt;
   logic        pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, exmem_flush, imemREN, dmemREN, dmemWEN, halt;
   logic [15:0] stall_cnt, flush_cnt;

   typedef struct {
      string       tag;
      logic [12:0] ctl;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   pipe_ctrl #(.CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_taken(mem_taken),
      .idex_memRead(idex_memRead), .idex_rt(idex_rt), .ifid_rs(ifid_rs),
      .ifid_rt(ifid_rt), .wb_halt(wb_halt),
      .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .imemREN(imemREN),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Order: pc_en redir ifid_en idex_en exmem_en memwb_en ifid_fl idex_fl exmem_fl imem dren dwen halt
   function automatic logic [12:0] ctl(input logic pe, rd, ie, de, ee, me,
                                       input logic ifl, dfl, efl, im, dr, dw, h);
      return {pe, rd, ie, de, ee, me, ifl, dfl, efl, im, dr, dw, h};
   endfunction

   function automatic logic [12:0] norm(input logic dr, input logic dw);
      return ctl(1, 0, 1, 1, 1, 1, 0, 0, 0, 1, dr, dw, 0);
   endfunction

   task automatic idle_inputs();
      RST = 0; ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_taken = 0;
      idex_memRead = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; wb_halt = 0;
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic check(input string tag, input logic [12:0] c, input int sc, input int fc);
      exp_t e, g;
      logic [12:0] obs;
      e.tag = tag; e.ctl = c; e.sc = 16'(sc); e.fc = 16'(fc);
      exp_q.push_back(e);
      #4;
      g = exp_q.pop_front();
      obs = {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
             idex_flush, exmem_flush, imemREN, dmemREN, dmemWEN, halt};
      n_cmp++;
      assert (obs === g.ctl) else begin
         n_err++;
         $error("FAIL %s ctl observed=%b expected=%b", g.tag, obs, g.ctl);
      end
      n_cmp++;
      assert (stall_cnt === g.sc) else begin
         n_err++;
         $error("FAIL %s stall_cnt observed=%0d expected=%0d", g.tag, stall_cnt, g.sc);
      end
      n_cmp++;
      assert (flush_cnt === g.fc) else begin
         n_err++;
         $error("FAIL %s flush_cnt observed=%0d expected=%0d", g.tag, flush_cnt, g.fc);
      end
      @(posedge CLK); #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
      end
   endtask

   localparam logic [12:0] STALL_R = 13'b0000000001100; // dstall, dREN request visible
   localparam logic [12:0] NOHIT   = 13'b0011111001000;

   initial begin
      idle_inputs();
      RST = 1;
      @(posedge CLK); #1;
      run_cycles(1);
      RST = 0;

      // Reset state and steady flow
      for (int i = 0; i < 10; i++) check("run", norm(0, 0), 0, 0);

      // Data miss: 3 stall cycles, release on dhit
      mem_dREN = 1; dhit = 0;
      for (int i = 0; i < 3; i++) check("dstall", STALL_R, i, 0);
      dhit = 1;
      check("dhit_release", norm(1, 0), 3, 0);
      idle_inputs();
      check("after_dwait", norm(0, 0), 3, 0);
      mem_dREN = 1; dhit = 1;
      check("dhit_same_cycle", norm(1, 0), 3, 0);
      idle_inputs();

      // Load-use on rt, then rt=0 must not stall
      idex_memRead = 1; idex_rt = 8; ifid_rt = 8;
      check("luse", ctl(0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0), 3, 0);
      idex_rt = 0; ifid_rt = 0;
      check("luse_r0", norm(0, 0), 4, 0);

      // Fetch miss
      idle_inputs(); ihit = 0;
      check("ifetch_miss", NOHIT, 4, 0);

      // Redirect beats load-use and missing ihit
      idle_inputs(); ihit = 0; mem_taken = 1;
      idex_memRead = 1; idex_rt = 8; ifid_rs = 8;
      check("redirect", ctl(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0), 5, 0);
      idle_inputs();
      check("post_redirect", norm(0, 0), 5, 1);

      // Halt with an outstanding store miss
      wb_halt = 1; mem_dWEN = 1; dhit = 0;
      check("wb_halt", ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 5, 1);
      for (int i = 0; i < 20; i++) check("halted", 13'b0000000000001, 6, 1);
      idle_inputs(); RST = 1;
      check("rst_from_halt", ctl(1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1), 6, 1);
      RST = 0;
      check("after_halt_rst", norm(0, 0), 0, 0);

      // Reset while waiting on data
      mem_dREN = 1; dhit = 0;
      check("dwait_pre_rst", STALL_R, 0, 0);
      RST = 1;
      check("rst_in_dwait", STALL_R, 1, 0);
      idle_inputs();
      check("after_dwait_rst", norm(0, 0), 0, 0);

      // Saturation of stall_cnt
      ihit = 0;
      check("sat_start", NOHIT, 0, 0);
      run_cycles(65529);
      check("sat_near", NOHIT, 65530, 0);
      run_cycles(10);
      check("sat_full", NOHIT, 65535, 0);
      check("sat_hold", NOHIT, 65535, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
